axi_read_master: RTL

Single-channel AXI4 read master that sits directly downstream of `axi_read_arb`. It accepts one granted read command (byte address and byte length) through the arbiter's start/done handshake and splits it into AXI4 INCR bursts that never cross a 4 KB boundary. It forwards the returned R-channel data as an AXI-Stream to the arbiter, which routes it to the winning requester.

---
 rtl/axi_read_master.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axi_read_master.sv
// axi_read_master: splits one byte-addressed read command into 4 KB-safe AXI4 INCR bursts and streams R data out.
// Define AXI_READ_MASTER_RRESP_CHECK_EN to build the sticky read_err check on rresp and rlast.
module axi_read_master #(
    parameter int AXI_ADDR_BITWIDTH = 29,
    parameter int AXI_DATA_BITWIDTH = 128,
    parameter int MAX_BURST         = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         cmd_start,
    input  logic [AXI_ADDR_BITWIDTH-1:0] cmd_addr,
    input  logic [AXI_ADDR_BITWIDTH-1:0] cmd_len,
    output logic                         cmd_done,
    input  logic                         axis_ready,
    output logic                         axis_valid,
    output logic [AXI_DATA_BITWIDTH-1:0] axis_data,
    output logic                         axis_last,
    output logic [AXI_ADDR_BITWIDTH-1:0] m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    output logic [2:0]                   m_axi_arsize,
    output logic [1:0]                   m_axi_arburst,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    input  logic [AXI_DATA_BITWIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rlast,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    output logic                         read_err
);
    localparam int AW    = AXI_ADDR_BITWIDTH;
    localparam int BYTES = AXI_DATA_BITWIDTH / 8;
    localparam int LG    = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, CALC, AR, RD} state_t;

    state_t        r_state, w_next;
    logic          r_cmd_done;
    logic [AW-1:0] r_cur_addr, r_rem_beats, r_araddr;
    logic [7:0]    r_arlen;
    logic [8:0]    r_burst_beats, r_beat_cnt, w_burst_beats;
    logic [12:0]   w_page_beats, w_cap;
    logic          w_rhs, w_burst_end, w_accept;

    // Beats left before the next 4 KB page, then clamped by MAX_BURST and the remaining length.
    assign w_page_beats  = (13'h1000 - {1'b0, r_cur_addr[11:0]}) >> LG;
    assign w_cap         = (w_page_beats < 13'(MAX_BURST)) ? w_page_beats : 13'(MAX_BURST);
    assign w_burst_beats = (r_rem_beats < AW'(w_cap)) ? r_rem_beats[8:0] : w_cap[8:0];

    assign w_accept    = (r_state == IDLE) && cmd_start && r_cmd_done;
    assign w_rhs       = (r_state == RD) && m_axi_rvalid && axis_ready;
    assign w_burst_end = (r_beat_cnt == r_burst_beats - 9'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? CALC : IDLE;
            CALC:    w_next = (r_rem_beats == '0) ? IDLE : AR;
            AR:      w_next = m_axi_arready ? RD : AR;
            RD:      w_next = (w_rhs && w_burst_end) ? CALC : RD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cmd_done    <= 1'b0;
            r_cur_addr    <= '0;
            r_rem_beats   <= '0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_burst_beats <= '0;
            r_beat_cnt    <= '0;
        end else begin
            r_cmd_done <= (w_next == IDLE);
            case (r_state)
                IDLE: if (w_accept) begin
                    r_cur_addr  <= cmd_addr;
                    r_rem_beats <= cmd_len >> LG;
                end
                CALC: if (r_rem_beats != '0) begin
                    r_burst_beats <= w_burst_beats;
                    r_araddr      <= r_cur_addr;
                    r_arlen       <= 8'(w_burst_beats - 9'd1);
                end
                AR: if (m_axi_arready) r_beat_cnt <= '0;
                RD: if (w_rhs) begin
                    r_beat_cnt <= r_beat_cnt + 9'd1;
                    if (w_burst_end) begin
                        r_rem_beats <= r_rem_beats - AW'(r_burst_beats);
                        r_cur_addr  <= r_cur_addr + (AW'(r_burst_beats) << LG);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_done      = r_cmd_done;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'(LG);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (r_state == AR);
    assign m_axi_rready  = (r_state == RD) && axis_ready;
    assign axis_valid    = (r_state == RD) && m_axi_rvalid;
    assign axis_data     = m_axi_rdata;
    // Only the final beat of the final burst closes the stream.
    assign axis_last     = (r_state == RD) && w_burst_end && (r_rem_beats == AW'(r_burst_beats));

`ifdef AXI_READ_MASTER_RRESP_CHECK_EN
    logic r_read_err;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_read_err <= 1'b0;
        else if (w_rhs && ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_burst_end)))
            r_read_err <= 1'b1;
    end
    assign read_err = r_read_err;
`else
    logic w_unused;
    assign w_unused = ^{m_axi_rresp, m_axi_rlast};
    assign read_err = 1'b0;
`endif
endmodule
